// File: rtl/rf_pkg.sv
// Shared widths, types and constants for the multi-port register file.
package rf_pkg;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);
    localparam int RF_ZERO_REG = 0;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy flags for RAW hazard detection: reservation sets, writeback clears.
// Flags change one edge after the request; no backpressure, a write is never refused.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rsv_en_i,
    input  logic [ADDR_W-1:0]   rsv_addr_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                any_busy_o
);

    logic [NUM_REGS-1:0] busy_d, busy_q;
    logic                rsv_ok, clr_ok;

    // R0 can never be reserved, so its flag stays 0 from reset onwards.
    assign rsv_ok = rsv_en_i && (32'(rsv_addr_i) < NUM_REGS) && (32'(rsv_addr_i) != RF_ZERO_REG);
    assign clr_ok = wr_en_i  && (32'(wr_addr_i)  < NUM_REGS);

    // Clear first, then set: a reservation in the same cycle as writeback wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_ok) busy_d[wr_addr_i]  = 1'b0;
        if (rsv_ok) busy_d[rsv_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign any_busy_o = |busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with busy scoreboard; R0 reads zero. Option macro: RF_BYPASS_EN.
// Reads take 1 cycle (data held while rd_en low); no backpressure, decode stalls on rd_busy.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int  DATA_W   = RF_DATA_W,
    parameter int  NUM_REGS = RF_NUM_REGS,
    parameter int  NUM_RD   = 2,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     any_busy
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_ok;

    assign wr_ok = wr_en && (32'(wr_addr) < NUM_REGS) && (32'(wr_addr) != RF_ZERO_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .busy_o     (busy),
        .any_busy_o (any_busy)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              addr_ok;
        logic [DATA_W-1:0] rdata_d, rdata_q;

        assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
        assign addr_ok = (32'(addr) < NUM_REGS) && (32'(addr) != RF_ZERO_REG);

`ifdef RF_BYPASS_EN
        logic fwd;
        assign fwd = rd_en[p] && wr_ok && (wr_addr == addr);

        always_comb begin
            rdata_d = rdata_q;
            if (fwd) begin
                rdata_d = wr_data;
            end else if (rd_en[p]) begin
                rdata_d = addr_ok ? regs_q[addr] : '0;
            end
        end

        // A forwarded write resolves the hazard now, unless the same cycle re-reserves it.
        assign rd_busy[p] = addr_ok && busy[addr] && !(fwd && !(rsv_en && (rsv_addr == addr)));
`else
        always_comb begin
            rdata_d = rdata_q;
            if (rd_en[p]) begin
                rdata_d = addr_ok ? regs_q[addr] : '0;
            end
        end

        assign rd_busy[p] = addr_ok && busy[addr];
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rdata_q;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboarded bench for reg_file_mp: a 2-port 32-entry instance and a 1-port 24-entry instance.
module tb_reg_file_mp;
    import rf_pkg::*;

    localparam int AW  = 5;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rd_en_a   = '0;
    logic [2*AW-1:0] rd_addr_a = '0;
    logic [63:0]   rd_data_a;
    logic [1:0]    rd_busy_a;
    logic          wr_en_a   = 1'b0;
    logic [AW-1:0] wr_addr_a = '0;
    rf_data_t      wr_data_a = '0;
    logic          rsv_en_a  = 1'b0;
    logic [AW-1:0] rsv_addr_a = '0;
    logic          any_busy_a;

    logic [0:0]    rd_en_b   = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic [31:0]   rd_data_b;
    logic [0:0]    rd_busy_b;
    logic          wr_en_b   = 1'b0;
    logic [AW-1:0] wr_addr_b = '0;
    logic [31:0]   wr_data_b = '0;
    logic          rsv_en_b  = 1'b0;
    logic [AW-1:0] rsv_addr_b = '0;
    logic          any_busy_b;

    reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a), .any_busy(any_busy_a)
    );

    reg_file_mp #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b), .any_busy(any_busy_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a0[$];
    exp_t q_a1[$];
    exp_t q_b0[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Read results appear one edge after rd_en; this pipe marks when to pop.
    logic [2:0] vld_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= {rd_en_b, rd_en_a};
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (vld_q[0]) begin
                if (q_a0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a0_spurious: got 0x%08h, expected no read", rd_data_a[31:0]);
                end else begin
                    e = q_a0.pop_front();
                    check(e.name, rd_data_a[31:0], e.val);
                end
            end
            if (vld_q[1]) begin
                if (q_a1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a1_spurious: got 0x%08h, expected no read", rd_data_a[63:32]);
                end else begin
                    e = q_a1.pop_front();
                    check(e.name, rd_data_a[63:32], e.val);
                end
            end
            if (vld_q[2]) begin
                if (q_b0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b0_spurious: got 0x%08h, expected no read", rd_data_b);
                end else begin
                    e = q_b0.pop_front();
                    check(e.name, rd_data_b, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        rd_en_a = '0; wr_en_a = 1'b0; rsv_en_a = 1'b0;
        rd_en_b = '0; wr_en_b = 1'b0; rsv_en_b = 1'b0;
    endtask

    task automatic rd_a(input int p, input logic [AW-1:0] addr, input logic [31:0] val, input string name);
        exp_t e;
        e.name = name;
        e.val  = val;
        rd_en_a[p] = 1'b1;
        rd_addr_a[p*AW +: AW] = addr;
        if (p == 0) q_a0.push_back(e);
        else        q_a1.push_back(e);
    endtask

    task automatic rd_b(input logic [AW-1:0] addr, input logic [31:0] val, input string name);
        exp_t e;
        e.name = name;
        e.val  = val;
        rd_en_b   = 1'b1;
        rd_addr_b = addr;
        q_b0.push_back(e);
    endtask

    task automatic wr_a(input logic [AW-1:0] addr, input logic [31:0] val);
        wr_en_a = 1'b1; wr_addr_a = addr; wr_data_a = val;
    endtask

    task automatic wr_b(input logic [AW-1:0] addr, input logic [31:0] val);
        wr_en_b = 1'b1; wr_addr_b = addr; wr_data_b = val;
    endtask

    task automatic rsv_a(input logic [AW-1:0] addr);
        rsv_en_a = 1'b1; rsv_addr_a = addr;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench did not finish in time");
    end

    initial begin : stimulus
        // Reset state, sampled while rst_n is low.
        #12;
        check("rst_data_a", rd_data_a[31:0], 32'h0);
        check("rst_data_a1", rd_data_a[63:32], 32'h0);
        check("rst_any_busy", 32'(any_busy_a), 32'h0);
        #10 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            idle();
            rd_a(0, AW'(i), 32'h0, $sformatf("init_p0_r%0d", i));
            rd_a(1, AW'(i), 32'h0, $sformatf("init_p1_r%0d", i));
            #1;
            check($sformatf("init_busy_r%0d", i), 32'(rd_busy_a), 32'h0);
            check($sformatf("init_any_r%0d", i), 32'(any_busy_a), 32'h0);
            tick();
        end

        // Basic write/read, both ports on one address, R0 stays zero.
        idle(); wr_a(5, 32'hDEADBEEF); tick();
        idle(); rd_a(0, 5, 32'hDEADBEEF, "r5_p0"); rd_a(1, 5, 32'hDEADBEEF, "r5_p1"); tick();
        idle(); wr_a(0, 32'h1234); tick();
        idle(); rd_a(0, 0, 32'h0, "r0_zero"); tick();

        // Same-cycle write and read of R7.
        idle(); wr_a(7, 32'h11); tick();
        idle(); wr_a(7, 32'hA5A5A5A5); rd_a(0, 7, BYP ? 32'hA5A5A5A5 : 32'h11, "r7_same_cycle"); tick();
        idle(); rd_a(0, 7, 32'hA5A5A5A5, "r7_next_p0"); rd_a(1, 7, 32'hA5A5A5A5, "r7_next_p1"); tick();

        // Scoreboard set, clear, tie and re-reserve on R3.
        idle(); rsv_a(3); tick();
        idle(); rd_addr_a = {AW'(0), AW'(3)}; #1;
        check("r3_busy_set", 32'(rd_busy_a), 32'h1);
        check("r3_any_set", 32'(any_busy_a), 32'h1);
        wr_a(3, 32'h33); tick(); idle(); #1;
        check("r3_busy_clr", 32'(rd_busy_a[0]), 32'h0);
        check("r3_any_clr", 32'(any_busy_a), 32'h0);
        rsv_a(3); wr_a(3, 32'h44); tick(); idle(); #1;
        check("r3_rsv_wins", 32'(rd_busy_a[0]), 32'h1);
        rsv_a(3); tick(); idle(); #1;
        check("r3_rsv_again", 32'(rd_busy_a[0]), 32'h1);
        wr_a(3, 32'h55); tick(); idle(); #1;
        check("r3_busy_clr2", 32'(rd_busy_a[0]), 32'h0);
        rd_a(0, 3, 32'h55, "r3_data"); tick();
        idle(); wr_a(10, 32'hAB); tick();
        idle(); rd_a(1, 10, 32'hAB, "r10_data"); #1;
        check("r10_not_busy", 32'(rd_busy_a[1]), 32'h0);
        tick();

        // Forwarding effect on rd_busy and read data for R12.
        idle(); rsv_a(12); tick();
        idle(); wr_a(12, 32'hC0C0); rd_a(0, 12, BYP ? 32'hC0C0 : 32'h0, "r12_fwd"); #1;
        check("r12_busy_fwd", 32'(rd_busy_a[0]), BYP ? 32'h0 : 32'h1);
        tick(); idle(); #1;
        check("r12_busy_after", 32'(rd_busy_a[0]), 32'h0);
        rsv_a(12); tick();
        idle(); wr_a(12, 32'hC1C1); rsv_a(12); rd_a(0, 12, BYP ? 32'hC1C1 : 32'hC0C0, "r12_fwd_rsv"); #1;
        check("r12_busy_rsv_tie", 32'(rd_busy_a[0]), 32'h1);
        tick();
        idle(); wr_a(12, 32'hC2C2); tick(); idle(); #1;
        check("r12_any_clr", 32'(any_busy_a), 32'h0);

        // Read data holds while rd_en is low.
        idle(); wr_a(9, 32'h99); tick();
        idle(); rd_a(1, 9, 32'h99, "r9_first"); tick();
        idle(); wr_a(9, 32'h1999); tick();
        idle(); tick();
        check("r9_hold", rd_data_a[63:32], 32'h99);
        rd_a(1, 9, 32'h1999, "r9_new"); tick();

        // Out-of-range addresses on the 24-entry instance.
        idle(); wr_b(4, 32'h4444); tick();
        idle(); wr_b(23, 32'h2323); tick();
        idle(); wr_b(28, 32'hBAD); rsv_en_b = 1'b1; rsv_addr_b = 28; tick();
        idle(); rd_b(28, 32'h0, "b_r28_zero"); #1;
        check("b_r28_busy", 32'(rd_busy_b), 32'h0);
        check("b_any_oor", 32'(any_busy_b), 32'h0);
        tick();
        idle(); rd_b(4, 32'h4444, "b_r4_intact"); tick();
        idle(); rd_b(23, 32'h2323, "b_r23_last"); tick();
        idle(); rsv_en_b = 1'b1; rsv_addr_b = 23; tick();
        idle(); rd_addr_b = 23; #1;
        check("b_r23_busy", 32'(rd_busy_b), 32'h1);
        check("b_any_set", 32'(any_busy_b), 32'h1);
        tick();

        // Asynchronous reset in the middle of activity.
        idle(); rsv_a(4); tick();
        idle(); rsv_a(8); tick();
        idle(); wr_a(2, 32'h2222); tick();
        idle(); rd_a(0, 2, 32'h2222, "r2_pre_rst"); rd_a(1, 2, 32'h2222, "r2_pre_rst_p1"); tick();
        idle(); rd_addr_a = {AW'(8), AW'(4)}; tick();
        #1;
        check("pre_rst_busy", 32'(rd_busy_a), 32'h3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_data_p0", rd_data_a[31:0], 32'h0);
        check("arst_data_p1", rd_data_a[63:32], 32'h0);
        check("arst_busy", 32'(rd_busy_a), 32'h0);
        check("arst_any", 32'(any_busy_a), 32'h0);
        check("arst_data_b", rd_data_b, 32'h0);
        check("arst_any_b", 32'(any_busy_b), 32'h0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        idle(); rd_a(0, 2, 32'h0, "r2_post_rst"); rd_a(1, 5, 32'h0, "r5_post_rst"); tick();
        idle(); tick(); tick();

        check("q_a0_empty", 32'(q_a0.size()), 32'h0);
        check("q_a1_empty", 32'(q_a1.size()), 32'h0);
        check("q_b0_empty", 32'(q_b0.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
